// File: rtl/mem_access_unit.sv
// MEM-stage controller: req/ack handshake to a multi-cycle data memory, owns MEM/WB register.
// Access stalls the pipeline for 2+k cycles (k = ack delay); non-memory ops pass with 1-cycle latency.
module mem_access_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        memRegIn,
    input  logic        regWriteIn,
    input  logic        memWriteIn,
    input  logic        memReadIn,
    input  logic [31:0] aluIn,
    input  logic [31:0] memWriteDataIn,
    input  logic [4:0]  regWriteAddressIn,
    input  logic        memAck,
    input  logic [31:0] memRdata,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memWdata,
    output logic        stall,
    output logic        memRegOut,
    output logic        regWriteOut,
    output logic [4:0]  regWriteAddressOut,
    output logic [31:0] aluOut,
    output logic [31:0] readDataOut
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [31:0] load_buf_q;
    logic        mem_reg_q;
    logic        reg_write_q;
    logic [4:0]  reg_waddr_q;
    logic [31:0] alu_q;
    logic [31:0] read_data_q;
    logic        access;

    assign access = memReadIn | memWriteIn;
    assign stall  = ~reset & (((state_q == IDLE) & access) | (state_q == BUSY));
    // Request comes only from the state register so a glitchy EX/MEM input can never reissue it.
    assign memReq = (state_q == BUSY);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            load_buf_q  <= '0;
            mem_reg_q   <= 1'b0;
            reg_write_q <= 1'b0;
            reg_waddr_q <= '0;
            alu_q       <= '0;
            read_data_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (access) begin
                        mem_addr_q  <= aluIn;
                        mem_wdata_q <= memWriteDataIn;
                        mem_we_q    <= memWriteIn;
                        state_q     <= BUSY;
                    end
                end
                BUSY: begin
                    if (memAck) begin
                        // Stores (including read+write, where the write wins) return no data.
                        load_buf_q <= mem_we_q ? 32'd0 : memRdata;
                        state_q    <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase

            if (stall) begin
                mem_reg_q   <= 1'b0;
                reg_write_q <= 1'b0;
                reg_waddr_q <= '0;
                alu_q       <= '0;
                read_data_q <= '0;
            end else begin
                mem_reg_q   <= memRegIn;
                reg_write_q <= regWriteIn;
                reg_waddr_q <= regWriteAddressIn;
                alu_q       <= aluIn;
                read_data_q <= (state_q == DONE) ? load_buf_q : 32'd0;
            end
        end
    end

    assign memWe              = mem_we_q;
    assign memAddr            = mem_addr_q;
    assign memWdata           = mem_wdata_q;
    assign memRegOut          = mem_reg_q;
    assign regWriteOut        = reg_write_q;
    assign regWriteAddressOut = reg_waddr_q;
    assign aluOut             = alu_q;
    assign readDataOut        = read_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with request and write-back scoreboards.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        memRegIn, regWriteIn, memWriteIn, memReadIn;
    logic [31:0] aluIn, memWriteDataIn;
    logic [4:0]  regWriteAddressIn;
    logic        memAck;
    logic [31:0] memRdata;
    logic        memReq, memWe, stall;
    logic [31:0] memAddr, memWdata;
    logic        memRegOut, regWriteOut;
    logic [4:0]  regWriteAddressOut;
    logic [31:0] aluOut, readDataOut;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk(clk), .reset(reset),
        .memRegIn(memRegIn), .regWriteIn(regWriteIn),
        .memWriteIn(memWriteIn), .memReadIn(memReadIn),
        .aluIn(aluIn), .memWriteDataIn(memWriteDataIn),
        .regWriteAddressIn(regWriteAddressIn),
        .memAck(memAck), .memRdata(memRdata),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
        .stall(stall),
        .memRegOut(memRegOut), .regWriteOut(regWriteOut),
        .regWriteAddressOut(regWriteAddressOut),
        .aluOut(aluOut), .readDataOut(readDataOut)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic        mr;
        logic        rw;
        logic [4:0]  ra;
        logic [31:0] alu;
        logic [31:0] rd;
    } wb_t;

    req_t exp_req[$];
    wb_t  exp_wb[$];
    req_t cur_req;

    int n_cmp = 0;
    int n_err = 0;
    int stall_cnt, req_cnt, low_cnt;
    logic seen_req, req_prev, stall_prev;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_wb_zero(input string tag);
        chk({tag, ".memReg"},   {31'd0, memRegOut},   32'd0);
        chk({tag, ".regWrite"}, {31'd0, regWriteOut}, 32'd0);
        chk({tag, ".regAddr"},  {27'd0, regWriteAddressOut}, 32'd0);
        chk({tag, ".alu"},      aluOut,      32'd0);
        chk({tag, ".readData"}, readDataOut, 32'd0);
    endtask

    // Per-cycle monitor: request scoreboard, stability, gap and bubble checks.
    task automatic sample();
        if (memReq && !req_prev) begin
            if (seen_req) chk("req_gap_ge2", {31'd0, low_cnt >= 2}, 32'd1);
            seen_req = 1'b1;
            if (exp_req.size() == 0) begin
                chk("unexpected_req", {31'd0, memReq}, 32'd0);
            end else begin
                cur_req = exp_req.pop_front();
                chk("req.we",    {31'd0, memWe}, {31'd0, cur_req.we});
                chk("req.addr",  memAddr,  cur_req.addr);
                chk("req.wdata", memWdata, cur_req.wdata);
            end
        end else if (memReq) begin
            if (memWe !== cur_req.we || memAddr !== cur_req.addr || memWdata !== cur_req.wdata)
                chk("req_stable", memAddr ^ cur_req.addr ^ memWdata ^ cur_req.wdata ^ {31'd0, memWe ^ cur_req.we} ^ 32'd1, 32'd0);
        end
        if (stall_prev) begin
            if (regWriteOut !== 1'b0 || memRegOut !== 1'b0 || aluOut !== 32'd0 || readDataOut !== 32'd0)
                chk("bubble_after_stall", {31'd0, regWriteOut} | aluOut | readDataOut | {31'd0, memRegOut}, 32'd0);
        end
        low_cnt    = memReq ? 0 : low_cnt + 1;
        stall_cnt += stall ? 1 : 0;
        req_cnt   += memReq ? 1 : 0;
        req_prev   = memReq;
        stall_prev = stall;
    endtask

    task automatic cyc();
        #2;
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic mr, input logic rw,
                         input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] ra);
        memReadIn = rd; memWriteIn = wr; memRegIn = mr; regWriteIn = rw;
        aluIn = alu; memWriteDataIn = wd; regWriteAddressIn = ra;
    endtask

    task automatic nop();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    endtask

    task automatic check_wb(input string tag);
        wb_t e;
        if (exp_wb.size() == 0) begin
            chk({tag, ".no_expected"}, 32'd1, 32'd0);
        end else begin
            e = exp_wb.pop_front();
            chk({tag, ".memReg"},   {31'd0, memRegOut},   {31'd0, e.mr});
            chk({tag, ".regWrite"}, {31'd0, regWriteOut}, {31'd0, e.rw});
            chk({tag, ".regAddr"},  {27'd0, regWriteAddressOut}, {27'd0, e.ra});
            chk({tag, ".alu"},      aluOut,      e.alu);
            chk({tag, ".readData"}, readDataOut, e.rd);
        end
    endtask

    // Runs one access with ack k cycles after memReq rises; returns just after the DONE edge.
    task automatic do_access(input string tag, input logic rd, input logic wr, input logic mr,
                             input logic rw, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [4:0] ra, input logic [31:0] rdata, input int k);
        exp_req.push_back('{we: wr, addr: addr, wdata: wd});
        exp_wb.push_back('{mr: mr, rw: rw, ra: ra, alu: addr, rd: (wr ? 32'd0 : rdata)});
        drive(rd, wr, mr, rw, addr, wd, ra);
        stall_cnt = 0;
        req_cnt   = 0;
        cyc();
        // Scramble EX/MEM while busy: request fields must not follow it.
        aluIn = 32'hFFFF_0000; memWriteDataIn = 32'h0BAD_0BAD;
        for (int i = 0; i < k; i++) begin
            memRdata = $urandom;
            cyc();
        end
        memAck = 1'b1; memRdata = rdata;
        cyc();
        memAck = 1'b0; memRdata = $urandom;
        drive(rd, wr, mr, rw, addr, wd, ra);
        cyc();
        chk({tag, ".stall_cycles"}, stall_cnt, 2 + k);
        chk({tag, ".req_cycles"},   req_cnt,   1 + k);
        check_wb(tag);
    endtask

    initial begin
        reset = 1'b1; memAck = 1'b0; memRdata = 32'd0;
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h1234, 32'h5678, 5'd3);
        seen_req = 1'b0; req_prev = 1'b0; stall_prev = 1'b0; low_cnt = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("reset.stall_forced", {31'd0, stall}, 32'd0);
        chk("reset.memReq", {31'd0, memReq}, 32'd0);
        chk("reset.memWe", {31'd0, memWe}, 32'd0);
        chk("reset.memAddr", memAddr, 32'd0);
        chk("reset.memWdata", memWdata, 32'd0);
        chk_wb_zero("reset.wb");
        reset = 1'b0;
        nop();
        cyc();

        // Plain ALU op
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 32'd0, 5'd5);
        exp_wb.push_back('{mr: 1'b0, rw: 1'b1, ra: 5'd5, alu: 32'h10, rd: 32'd0});
        #1;
        chk("alu.stall", {31'd0, stall}, 32'd0);
        cyc();
        check_wb("alu");
        nop();
        cyc();

        do_access("load", 1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 32'd0, 5'd7, 32'hDEADBEEF, 3);
        nop();
        cyc();

        do_access("store", 1'b0, 1'b1, 1'b0, 1'b0, 32'h200, 32'hCAFEF00D, 5'd0, 32'h1357_9BDF, 0);
        nop();
        cyc();
        cyc();

        // Load immediately followed by store
        do_access("b2b_load", 1'b1, 1'b0, 1'b1, 1'b1, 32'h104, 32'd0, 5'd9, 32'hA5A5_0001, 1);
        do_access("b2b_store", 1'b0, 1'b1, 1'b0, 1'b0, 32'h208, 32'h7777_8888, 5'd0, 32'hFFFF_FFFF, 2);
        nop();
        cyc();

        // Reset in the second BUSY cycle, ack arrives afterwards
        exp_req.push_back('{we: 1'b0, addr: 32'h300, wdata: 32'h4444});
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h300, 32'h4444, 5'd4);
        cyc();
        cyc();
        reset = 1'b1;
        #1;
        chk("rst_busy.stall_forced", {31'd0, stall}, 32'd0);
        cyc();
        reset = 1'b0;
        nop();
        chk("rst_busy.memReq_next", {31'd0, memReq}, 32'd0);
        chk("rst_busy.memAddr", memAddr, 32'd0);
        chk("rst_busy.memWe", {31'd0, memWe}, 32'd0);
        chk_wb_zero("rst_busy.wb");
        memAck = 1'b1; memRdata = 32'hBAD0_BAD0;
        cyc();
        memAck = 1'b0;
        chk("rst_busy.late_ack_req", {31'd0, memReq}, 32'd0);
        chk("rst_busy.late_ack_stall", {31'd0, stall}, 32'd0);
        cyc();
        chk_wb_zero("rst_busy.after_ack");
        seen_req = 1'b0;

        // FSM back in IDLE: read+write together, write wins
        do_access("rdwr", 1'b1, 1'b1, 1'b1, 1'b1, 32'h400, 32'h1111_2222, 5'd12, 32'h5555_5555, 1);
        chk("rdwr.memWe", {31'd0, memWe}, 32'd1);
        nop();
        cyc();
        cyc();

        chk("req_queue_empty", exp_req.size(), 32'd0);
        chk("wb_queue_empty",  exp_wb.size(),  32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage controller sitting on the consumer side of the EX/MEM pipeline register. It decodes the EX/MEM control and data fields and runs a req/ack handshake with a multi-cycle data memory for loads and stores. It drives the `stall` line back into the pipeline registers while an access is outstanding, and it owns the MEM/WB register that feeds write-back.

## Interface
Parameters: none (address/data fixed at 32 bits, register address at 5 bits).

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- memRegIn  in  1  EX/MEM memReg (select load data for write-back)
- regWriteIn  in  1  EX/MEM regWrite
- memWriteIn  in  1  EX/MEM memWrite
- memReadIn  in  1  EX/MEM memRead
- aluIn  in  32  EX/MEM ALU result / memory address
- memWriteDataIn  in  32  EX/MEM store data
- regWriteAddressIn  in  5  EX/MEM destination register
- memAck  in  1  memory completion strobe, one cycle per access
- memRdata  in  32  load data, valid while memAck=1
- memReq  out  1  access request, held until acknowledged
- memWe  out  1  1=store, 0=load; valid while memReq=1
- memAddr  out  32  access address; valid while memReq=1
- memWdata  out  32  store data; valid while memReq=1
- stall  out  1  combinational; freezes PC, IF/ID, ID/EX and EX/MEM
- memRegOut  out  1  MEM/WB memReg
- regWriteOut  out  1  MEM/WB regWrite
- regWriteAddressOut  out  5  MEM/WB destination register
- aluOut  out  32  MEM/WB ALU result
- readDataOut  out  32  MEM/WB load data

## Operation
- FSM states:
  - IDLE: if (memReadIn|memWriteIn), latch aluIn into memAddr, memWriteDataIn into memWdata, and memWriteIn into memWe, then go to BUSY. Otherwise stay in IDLE.
  - BUSY: memReq=1. On memAck, latch memRdata into an internal load buffer (0 for stores) and go to DONE. Otherwise stay in BUSY.
  - DONE: go to IDLE unconditionally.
- stall = (state==IDLE & (memReadIn|memWriteIn)) | (state==BUSY). It is forced to 0 while reset=1.
- memReq = (state==BUSY). It is driven from the state register only, never from inputs.
- When memReadIn and memWriteIn are both 1, the write wins: memWe=1 and readDataOut=0.
- MEM/WB register update:
  - When stall=0, load memRegIn, regWriteIn, regWriteAddressIn and aluIn. readDataOut loads from the load buffer in DONE, and 0 otherwise.
  - When stall=1, load a bubble: all MEM/WB outputs 0.
- In DONE, EX/MEM is still holding the access instruction and stall=0. MEM/WB captures that instruction and EX/MEM advances on the same edge. The next IDLE cycle therefore sees the next instruction, so the access is never reissued.
- memAck is ignored in IDLE and DONE. memRdata is ignored unless memAck=1 in BUSY.
- Reset: state←IDLE. memReq, memWe, memAddr, memWdata, the load buffer and all MEM/WB outputs ←0.

## Timing
- Non-memory instruction: stall=0, and MEM/WB holds it 1 cycle after it appears on EX/MEM.
- Access appearing on EX/MEM in cycle 0, with memAck arriving k cycles after memReq first rises (k≥0):
  - stall is high in cycles 0..1+k, i.e. 2+k cycles.
  - memReq is high in cycles 1..1+k.
  - DONE is cycle 2+k.
  - MEM/WB outputs are valid from cycle 3+k.
- Minimum access (memAck in cycle 1): 2 stall cycles.
- memAddr, memWdata and memWe are stable for the whole time memReq=1, independent of EX/MEM inputs.
- Back-to-back accesses: the next access enters BUSY at the earliest 2 cycles after DONE (DONE→IDLE, then IDLE→BUSY). memReq drops for at least 2 cycles between accesses.
- Reset during BUSY: memReq=0 on the cycle after the reset edge. An ack pending at that point is dropped.

## Test plan
- ALU op (regWriteIn=1, aluIn=0x00000010, regWriteAddressIn=5, no mem) → stall stays 0; next cycle regWriteOut=1, aluOut=0x10, regWriteAddressOut=5, readDataOut=0.
- Load aluIn=0x00000100, memAck returned 3 cycles after memReq rises with memRdata=0xDEADBEEF → memReq high 4 cycles, memAddr=0x100, memWe=0, stall high 5 cycles; MEM/WB shows readDataOut=0xDEADBEEF, memRegOut=1; regWriteOut was 0 during every stall cycle.
- Store aluIn=0x200, memWriteDataIn=0xCAFEF00D, memAck in the first memReq cycle → stall high exactly 2 cycles, memWe=1, memWdata=0xCAFEF00D, readDataOut=0; no second request while the same instruction is still on EX/MEM in DONE.
- Load followed immediately by a store → two distinct memReq pulses separated by ≥2 low cycles, each with the correct address, and no duplicate request.
- Reset asserted in the 2nd BUSY cycle with memAck asserted later → memReq=0 from the next cycle, all outputs 0, late memAck ignored, FSM in IDLE.
- memReadIn=memWriteIn=1 → memWe=1, readDataOut=0 after completion.
